seq_match_fsm: RTL and testbench
================================

# seq_match_fsm

Parametrised Moore sequence detector. It shifts a valid-qualified serial bit stream into an N-bit history and compares that history against a programmable pattern. Overlap and non-overlap matching are both supported, and a saturating counter tracks matches. It replaces fixed-pattern 4-state detectors in the serial front end and is the standard detector for new serial-control paths.

## Interface
- N, default 4: pattern/history length in bits; legal range 2..16.
- CNT_W, default 8: width of the match counter; legal range 1..32.

- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; asserted at 0.
- x  input  1  serial data bit.
- valid  input  1  x is sampled only on cycles with valid=1.
- clear  input  1  synchronous restart; has priority over valid.
- overlap  input  1  1 = overlapping matches allowed; 0 = matched samples are consumed. Sampled every cycle.
- pattern  input  N  target sequence. Bit 0 is the newest sample. Compared combinationally every cycle.
- q  output  1  Moore match flag; 1 exactly while state is HIT.
- history  output  N  last N valid samples; newest at bit 0.
- filled  output  1  1 when at least N samples are held since the last restart.
- match_count  output  CNT_W  number of HIT entries; saturates at all-ones.

## Operation
- Internal fill counter, width clog2(N+1), saturating at N; filled = (fill == N).
- On a valid cycle (clear=0):
  - h_next = {history[N-2:0], x}
  - fill_next = min(fill+1, N)
  - hit = (fill_next == N) && (h_next == pattern)
- States and transitions. All transitions are evaluated only when clear=0; clear overrides everything.
  - FILL: valid && hit → HIT. valid && fill_next==N && !hit → RUN. Otherwise stay in FILL.
  - RUN: valid && hit → HIT. Otherwise stay in RUN.
  - HIT: valid && hit → HIT, which is a back-to-back match (overlap=1 only). Otherwise → RUN if overlap=1, or → FILL if overlap=0.
  - Illegal encoding → FILL.
- Non-overlap consumption: on a transition into HIT with overlap=0:
  - fill is set to 0 and history is set to 0.
  - The next match therefore needs N fresh valid samples.
- Overlap mode: entering HIT leaves history and fill as computed by the shift.
- match_count increments by 1 on every transition into HIT, including HIT→HIT. It holds at 2^CNT_W−1.
- clear=1:
  - history=0, fill=0, state=FILL, match_count=0.
  - x and valid are ignored that cycle.
- valid=0 cycles change nothing except the HIT exit described above.

## Timing
- Reset (reset=0, asynchronous): state=FILL, q=0, history=0, filled=0, match_count=0. Takes effect immediately, independent of clock.
- Reset release is synchronised by the system. The first sampling edge is the first rising clock edge with reset=1.
- Latency: q rises on the edge that samples the completing bit. It is visible for the following cycle: one cycle after x is presented.
- q pulse width:
  - 1 cycle per match.
  - Stays high across consecutive-cycle matches in overlap mode.
  - In non-overlap mode q is never high for more than 1 cycle, because N≥2.
- history, filled and match_count update on the same edge as state.
- Reset asserted mid-stream discards all partial progress. Nothing survives reset, including match_count.
- Changing pattern or overlap takes effect on the next sampling edge. No pipeline flush is needed.

## Test plan
- Reset value: drive reset=0 mid-run with history=4'b1010, match_count=3 → all outputs 0 immediately, before any clock edge. After release the state is FILL.
- Overlap match:
  - Setup: N=4, pattern=4'b1011, overlap=1.
  - Stimulus: valid bits 1,0,1,1,0,1,1.
  - Required: q=1 in the cycle after bit 4 and after bit 7; match_count=2; filled=1 from bit 4 onward.
- Non-overlap match:
  - Setup: same stream as above, overlap=0.
  - Required: q=1 only after bit 4; history=0 and filled=0 right after the hit; match_count=1.
- Valid gaps: same stream as the overlap case, with valid=0 inserted between every bit → same q pulses and match_count=2. History does not change on gap cycles. q falls on the first gap cycle after each hit.
- Back-to-back and saturation:
  - Setup: N=2, pattern=2'b11, CNT_W=2, overlap=1.
  - Stimulus: 6 consecutive valid 1s.
  - Required: q stays high from the cycle after bit 2 through the cycle after bit 6; match_count=3 (saturated).
- Clear priority: clear=1 together with valid=1 and x completing a match → no HIT; q=0; history=0; match_count=0; state=FILL.

Source files
------------

// File: rtl/seq_match_fsm.sv
// Programmable N-bit serial sequence detector (Moore) with overlap control and a saturating match counter.
// Latency: q rises one cycle after the completing bit is presented; history/filled/match_count update on the same edge.
// No backpressure: every cycle with valid=1 consumes x; clear restarts the detector and wins over valid.
module seq_match_fsm #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x,
    input  logic             valid,
    input  logic             clear,
    input  logic             overlap,
    input  logic [N-1:0]     pattern,
    output logic             q,
    output logic [N-1:0]     history,
    output logic             filled,
    output logic [CNT_W-1:0] match_count
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HIT  = 2'd2
    } state_t;

    state_t         state;
    logic [FW-1:0]  fill;
    logic [N-1:0]   h_next;
    logic [FW-1:0]  fill_next;
    logic           hit;
    logic           state_legal;
    logic           enter_hit;

    // Candidate shift result and match decision for this cycle's sample.
    always_comb begin
        h_next      = {history[N-2:0], x};
        fill_next   = (fill == FILL_FULL) ? fill : fill + FW'(1);
        hit         = valid && (fill_next == FILL_FULL) && (h_next == pattern);
        state_legal = (state == S_FILL) || (state == S_RUN) || (state == S_HIT);
        // An illegal encoding recovers to FILL and never produces a match.
        enter_hit   = hit && state_legal;
    end

    assign filled = (fill == FILL_FULL);

    // Detector FSM with registered match flag, history, fill and counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_FILL;
            q           <= 1'b0;
            history     <= '0;
            fill        <= '0;
            match_count <= '0;
        end else if (clear) begin
            state       <= S_FILL;
            q           <= 1'b0;
            history     <= '0;
            fill        <= '0;
            match_count <= '0;
        end else begin
            if (valid) begin
                history <= h_next;
                fill    <= fill_next;
            end

            case (state)
                S_FILL: begin
                    if (hit)
                        state <= S_HIT;
                    else if (valid && (fill_next == FILL_FULL))
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (hit)
                        state <= S_HIT;
                end
                S_HIT: begin
                    if (hit)
                        state <= S_HIT;
                    else
                        state <= overlap ? S_RUN : S_FILL;
                end
                default: state <= S_FILL;
            endcase

            q <= enter_hit;

            if (enter_hit) begin
                if (match_count != '1)
                    match_count <= match_count + CNT_W'(1);
                // Without overlap the matched samples are consumed, so the
                // next match must be built from N fresh samples.
                if (!overlap) begin
                    history <= '0;
                    fill    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_match_fsm.sv
// Bench for seq_match_fsm: two instances (N=4/CNT_W=8 and N=2/CNT_W=2) fed the same stream.
// A sample-level model predicts every output each cycle; directed checks pin the model.
// Inputs change on the falling edge, outputs are compared on the falling edge.
module tb_seq_match_fsm;

    logic       clock;
    logic       reset;
    logic       x;
    logic       valid;
    logic       clear;
    logic       overlap;
    logic [3:0] pattern_a;
    logic [1:0] pattern_b;

    logic       q_a, q_b;
    logic [3:0] history_a;
    logic [1:0] history_b;
    logic       filled_a, filled_b;
    logic [7:0] match_count_a;
    logic [1:0] match_count_b;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  cmp_en   = 0;

    seq_match_fsm #(.N(4), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .x(x), .valid(valid), .clear(clear),
        .overlap(overlap), .pattern(pattern_a), .q(q_a), .history(history_a),
        .filled(filled_a), .match_count(match_count_a)
    );

    seq_match_fsm #(.N(2), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .x(x), .valid(valid), .clear(clear),
        .overlap(overlap), .pattern(pattern_b), .q(q_b), .history(history_b),
        .filled(filled_b), .match_count(match_count_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: samples since the last restart/consumption, the most recent
    // samples packed newest-first, the match count, and whether the last
    // edge completed a match (which is exactly when q is high).
    int m_rec [2];
    int m_cnt [2];
    int m_mc  [2];
    bit m_q   [2];

    function automatic int nw(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 255 : 3;
    endfunction

    function automatic int pat(input int i);
        return (i == 0) ? int'(pattern_a) : int'(pattern_b);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_rec[i] <= 0;
                m_cnt[i] <= 0;
                m_mc[i]  <= 0;
                m_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int rec = m_rec[i];
                automatic int sc  = m_cnt[i];
                automatic int mc  = m_mc[i];
                automatic bit m   = 1'b0;
                if (clear) begin
                    rec = 0;
                    sc  = 0;
                    mc  = 0;
                end else if (valid) begin
                    rec = ((rec << 1) | int'(x)) & ((1 << nw(i)) - 1);
                    sc  = sc + 1;
                    if (sc >= nw(i) && rec == pat(i)) begin
                        m = 1'b1;
                        if (mc < cmax(i)) mc = mc + 1;
                        if (!overlap) begin
                            rec = 0;
                            sc  = 0;
                        end
                    end
                end
                m_rec[i] <= rec;
                m_cnt[i] <= sc;
                m_mc[i]  <= mc;
                m_q[i]   <= m;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("q_a",       32'(q_a),           32'(m_q[0]));
            chk("history_a", 32'(history_a),     32'(m_rec[0]));
            chk("filled_a",  32'(filled_a),      32'(m_cnt[0] >= 4));
            chk("count_a",   32'(match_count_a), 32'(m_mc[0]));
            chk("q_b",       32'(q_b),           32'(m_q[1]));
            chk("history_b", 32'(history_b),     32'(m_rec[1]));
            chk("filled_b",  32'(filled_b),      32'(m_cnt[1] >= 2));
            chk("count_b",   32'(match_count_b), 32'(m_mc[1]));
        end
    end

    task automatic drive(input logic xi, input logic vi, input logic ci);
        x     = xi;
        valid = vi;
        clear = ci;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    logic [6:0] stream;

    initial begin
        stream    = 7'b1011011;   // bit 6 is sent first: 1,0,1,1,0,1,1
        reset     = 1'b0;
        x         = 1'b0;
        valid     = 1'b0;
        clear     = 1'b0;
        overlap   = 1'b1;
        pattern_a = 4'b1011;
        pattern_b = 2'b11;

        #1;
        chk("rst_q",       32'(q_a),           0);
        chk("rst_history", 32'(history_a),     0);
        chk("rst_count",   32'(match_count_a), 0);
        @(negedge clock);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Overlapping matches.
        drive(0, 0, 1);
        for (int k = 1; k <= 7; k++) begin
            drive(stream[7-k], 1, 0);
            if (k == 4) begin
                chk("ov_q_bit4",      32'(q_a),      1);
                chk("ov_filled_bit4", 32'(filled_a), 1);
            end
            if (k == 5) chk("ov_q_bit5", 32'(q_a), 0);
            if (k == 7) begin
                chk("ov_q_bit7",  32'(q_a),           1);
                chk("ov_count",   32'(match_count_a), 2);
            end
        end

        // Build history 1010 with three matches, then reset asynchronously.
        drive(1, 1, 0); drive(0, 1, 0); drive(1, 1, 0); drive(1, 1, 0);
        drive(0, 1, 0); drive(1, 1, 0); drive(0, 1, 0);
        chk("pre_rst_history", 32'(history_a),     32'(4'b1010));
        chk("pre_rst_count",   32'(match_count_a), 3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_q",       32'(q_a),           0);
        chk("mid_rst_history", 32'(history_a),     0);
        chk("mid_rst_filled",  32'(filled_a),      0);
        chk("mid_rst_count",   32'(match_count_a), 0);
        @(negedge clock);
        reset = 1'b1;
        drive(1, 1, 0); drive(0, 1, 0); drive(1, 1, 0);
        chk("post_rst_filled", 32'(filled_a), 0);
        drive(1, 1, 0);
        chk("post_rst_q", 32'(q_a), 1);

        // Non-overlapping matches consume their samples.
        overlap = 1'b0;
        drive(0, 0, 1);
        for (int k = 1; k <= 7; k++) begin
            drive(stream[7-k], 1, 0);
            if (k == 4) begin
                chk("no_q_bit4",       32'(q_a),       1);
                chk("no_history_bit4", 32'(history_a), 0);
                chk("no_filled_bit4",  32'(filled_a),  0);
            end
            if (k == 7) begin
                chk("no_q_bit7", 32'(q_a),           0);
                chk("no_count",  32'(match_count_a), 1);
            end
        end

        // Overlap with a gap cycle after every bit.
        overlap = 1'b1;
        drive(0, 0, 1);
        for (int k = 1; k <= 7; k++) begin
            drive(stream[7-k], 1, 0);
            if (k == 4 || k == 7) chk("gap_q_hit", 32'(q_a), 1);
            drive(1, 0, 0);
            if (k == 4 || k == 7) begin
                chk("gap_q_fall",  32'(q_a),       0);
                chk("gap_history", 32'(history_a), 32'(4'b1011));
            end
        end
        chk("gap_count", 32'(match_count_a), 2);

        // Clear arrives together with the bit that would complete a match.
        drive(1, 1, 0); drive(0, 1, 0); drive(1, 1, 0);
        drive(1, 1, 1);
        chk("clr_q",       32'(q_a),           0);
        chk("clr_history", 32'(history_a),     0);
        chk("clr_count",   32'(match_count_a), 0);
        drive(1, 1, 0);
        chk("clr_restart_history", 32'(history_a), 1);
        chk("clr_restart_filled",  32'(filled_a),  0);

        // Back-to-back matches and counter saturation on the N=2 instance.
        drive(0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            drive(1, 1, 0);
            if (k >= 2) chk("b2b_q", 32'(q_b), 1);
        end
        chk("sat_count", 32'(match_count_b), 3);
        drive(0, 0, 0);
        chk("b2b_q_fall", 32'(q_b), 0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
